// File: rtl/acc_in_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_arb_pkg
//  Description : Shared constants, FSM state type and the round-robin pointer
//                helper for the input-SRAM read-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_arb_pkg;

    localparam int NREQ       = 3;
    localparam int REQ_WEIGHT = 0;
    localparam int REQ_IFMAP  = 1;
    localparam int REQ_HOST   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Next round-robin start position after a grant to idx, wrapping at n.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_in_sram_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_in_sram_arb_if
//  Description : Requester-side bus of the input-SRAM read arbiter: requests,
//                lock hints, packed addresses, grants and the return path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_in_sram_arb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 13,
    parameter int DW   = 32
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    // Requester side
    modport master (
        output req,
        output lock,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Arbiter side
    modport slave (
        input  req,
        input  lock,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/acc_in_sram_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : acc_rr_pick
//  Description : Combinational rotating-priority picker. Scans upward from
//                i_ptr (modulo NREQ) and returns the first set request as a
//                one-hot vector and as an index. A pointer >= NREQ acts as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_rr_pick #(
    parameter int NREQ = 3
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [1:0]      i_ptr,
    output logic      [NREQ-1:0] o_pick,
    output logic      [1:0]      o_idx,
    output logic                 o_any
);
    import acc_arb_pkg::*;

    int w_start;
    int w_pos;

    // Scan from farthest to nearest so the closest requester after the pointer wins.
    always_comb begin
        w_start = (int'(i_ptr) >= NREQ) ? 0 : int'(i_ptr);
        w_pos   = 0;
        o_idx   = 2'd0;
        o_any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = w_start + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (i_req[w_pos]) begin
                o_idx = 2'(w_pos);
                o_any = 1'b1;
            end
        end
        o_pick = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/acc_in_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : acc_in_sram_arb
//  Description : Read-port arbiter for the 8k x 32b accelerator input SRAM.
//                Round-robin among weight loader (0), ifmap streamer (1) and
//                host debug (2), with lockable bursts capped at MAX_BURST
//                grants and a fixed-latency, per-requester rvalid return.
//                Optional macro ACC_ARB_PERF_EN builds saturating 16-bit
//                per-requester wait counters; without it wait_cnt reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_in_sram_arb #(
    parameter int NREQ      = 3,
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    acc_in_sram_arb_if.slave      bus,
    output logic                  sram_rd_en,
    output logic [AW-1:0]         sram_raddr,
    input  wire logic [DW-1:0]    sram_rdata,
    output logic [1:0]            owner,
    output logic                  locked,
    input  wire logic             perf_clr,
    output logic [NREQ*16-1:0]    wait_cnt
);
    import acc_arb_pkg::*;

    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        w_rr_ptr_nxt;
    logic [1:0]        r_owner;
    logic [1:0]        w_owner_nxt;
    logic [BCW-1:0]    r_burst_cnt;
    logic [BCW-1:0]    w_burst_nxt;

    logic [NREQ-1:0]   w_req;
    logic [NREQ-1:0]   w_lock;
    logic [NREQ-1:0]   w_gnt;
    logic [NREQ-1:0]   w_own_oh;
    logic              w_own_hold;
    logic              w_burst_done;
    logic              w_keep;
    logic [NREQ-1:0]   w_pick_req;
    logic [NREQ-1:0]   w_pick_oh;
    logic [1:0]        w_pick_idx;
    logic              w_pick_any;
    logic [AW-1:0]     w_raddr;
    logic [NREQ-1:0]   r_rv_sr [RD_LAT];

    assign w_req        = bus.req;
    assign w_lock       = bus.lock;
    assign w_own_oh     = NREQ'(1) << r_owner;
    assign w_own_hold   = |(w_own_oh & w_req & w_lock);
    assign w_burst_done = (r_burst_cnt == BCW'(MAX_BURST));
    assign w_keep       = (r_state == ARB_LOCKED) && w_own_hold && !w_burst_done;

    // An owner that let go of req/lock must not win the release arbitration.
    assign w_pick_req = ((r_state == ARB_LOCKED) && !w_own_hold) ? (w_req & ~w_own_oh) : w_req;

    // While LOCKED, r_rr_ptr already equals owner+1 (set by the lock grant),
    // so the same picker also serves the forced-release arbitration.
    acc_rr_pick #(
        .NREQ   (NREQ)
    ) u_pick (
        .i_req  (w_pick_req),
        .i_ptr  (r_rr_ptr),
        .o_pick (w_pick_oh),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // Next-state and grant: keep feeding the lock owner, else arbitrate round-robin.
    always_comb begin
        w_gnt        = '0;
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_burst_nxt  = r_burst_cnt;
        if (w_keep) begin
            w_gnt       = w_own_oh;
            w_burst_nxt = r_burst_cnt + BCW'(1);
        end else begin
            w_state_nxt = ARB_IDLE;
            if (w_pick_any) begin
                w_gnt        = w_pick_oh;
                w_rr_ptr_nxt = next_ptr(w_pick_idx, NREQ);
                if (|(w_pick_oh & w_lock)) begin
                    w_state_nxt = ARB_LOCKED;
                    w_owner_nxt = w_pick_idx;
                    w_burst_nxt = BCW'(1);
                end
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= 2'd0;
            r_owner     <= 2'd0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Address mux: granted requester's address, zero when nobody is granted.
    always_comb begin
        w_raddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_raddr = w_raddr | bus.addr[i*AW +: AW];
            end
        end
    end

    // Return path: delay the grant vector by the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_rv_sr[k] <= '0;
            end
        end else begin
            r_rv_sr[0] <= w_gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rv_sr[k] <= r_rv_sr[k-1];
            end
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rv_sr[RD_LAT-1];
    assign bus.rdata  = sram_rdata;
    assign sram_rd_en = |w_gnt;
    assign sram_raddr = w_raddr;
    assign owner      = r_owner;
    assign locked     = (r_state == ARB_LOCKED);

`ifdef ACC_ARB_PERF_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_perf
        logic [15:0] r_wait;

        // Saturating wait counter; clear has priority over counting.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wait <= '0;
            end else if (perf_clr) begin
                r_wait <= '0;
            end else if (w_req[gi] && !w_gnt[gi] && (r_wait != 16'hFFFF)) begin
                r_wait <= r_wait + 16'd1;
            end
        end

        assign wait_cnt[gi*16 +: 16] = r_wait;
    end
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = perf_clr;
    assign wait_cnt          = '0;
`endif

endmodule
`default_nettype wire
